edge_detector_conv_ctrl: RTL and testbench
==========================================

# edge_detector_conv_ctrl

Sequencer for the 3x3 Sobel convolution of one pixel window. On `start_i` it steps the 3x3 kernel index through all nine taps and fetches each window pixel over a req/ack handshake. It drives the kernel-coefficient lookup with the same index and accumulates signed Gx/Gy. It then presents the saturated magnitude |Gx|+|Gy| over a valid/ready output port. It sits between the window/line-buffer pixel source and the Avalon-facing result writer.

## Interface
- `PIXEL_W`, 8: unsigned pixel width; also the result width.
- `ACC_W`, 12: signed accumulator width; must be >= PIXEL_W+3.
- `clk_i` in 1: clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin one window; sampled only in IDLE.
- `busy_o` out 1: high in any state other than IDLE.
- `Xindex_o` out 3: current tap row (0..2); feeds both the kernel lookup and the pixel source.
- `Yindex_o` out 3: current tap column (0..2).
- `Kx_i` in 3: signed Kx coefficient for (Xindex_o, Yindex_o), combinational from the lookup.
- `Ky_i` in 3: signed Ky coefficient, same timing as `Kx_i`.
- `pix_req_o` out 1: pixel request for tap (Xindex_o, Yindex_o).
- `pix_ack_i` in 1: pixel source acknowledge; `pix_data_i` is valid in the same cycle.
- `pix_data_i` in PIXEL_W: unsigned pixel.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: downstream ready.
- `res_data_o` out PIXEL_W: min(|Gx|+|Gy|, 2^PIXEL_W-1).
- `gx_o` out ACC_W: signed Gx, held alongside `res_data_o`.
- `gy_o` out ACC_W: signed Gy, held alongside `res_data_o`.

## Operation
- States:
  - IDLE: waiting for `start_i`.
  - REQ: fetching taps.
  - MAG: computing the magnitude.
  - OUT: presenting the result.
- IDLE -> REQ when `start_i`=1. Both accumulators clear to 0 and the tap index is set to (0,0).
- REQ:
  - `pix_req_o`=1. Index and request are held until `pix_ack_i`=1.
  - On ack, gx += pix*Kx_i and gy += pix*Ky_i. The pixel is zero-extended and the coefficients are sign-extended (3'b110 = -2, 3'b111 = -1).
  - The tap index then advances in row-major order: Yindex_o 0->1->2, then Xindex_o increments and Yindex_o returns to 0.
- REQ -> MAG on the ack of tap (2,2). The index returns to (0,0).
- MAG: registers gx_o, gy_o and res_data_o. Saturation is to all-ones of PIXEL_W. MAG -> OUT.
- OUT:
  - `res_valid_o`=1, with all result outputs stable.
  - OUT -> IDLE on the edge where `res_valid_o` and `res_ready_i` are both 1.
  - `start_i` in that same cycle is ignored.
- `start_i` while busy is ignored; there is no queueing.
- Arithmetic bounds: |product| <= 510 and |sum| <= 1020, so there is no overflow at ACC_W >= 11. Magnitude max 2040 before saturation.
- Reset values: every output is 0, state is IDLE, accumulators are 0.
- Reset mid-operation aborts immediately. The partial window is discarded and no result is emitted.

## Timing
- With ack every cycle: `start_i` at cycle 0; REQ cycles 1..9 (one tap per cycle); MAG at cycle 10; `res_valid_o` first high at cycle 11.
- Each cycle with `pix_ack_i` low adds one cycle of latency.
- `pix_ack_i` is ignored outside REQ.
- Minimum back-to-back period is 12 cycles: the return to IDLE costs one cycle before the next `start_i` is accepted.
- `res_valid_o` never drops without a handshake, and result outputs never change while valid.

## Structure
- `edge_detector_pkg` contains:
  - the state enum (IDLE, REQ, MAG, OUT);
  - `TAP_COUNT` = 9;
  - default PIXEL_W and ACC_W.
- One sub-module, `edge_detector_mag`: combinational abs/abs/add/saturate from (gx, gy) to PIXEL_W, reused by later pipelined variants.
- The coefficient lookup stays external and is connected through `Xindex_o`/`Yindex_o`/`Kx_i`/`Ky_i`.

## Test plan
- Uniform window, all pixels 100, ack every cycle -> gx=0, gy=0, res_data_o=0; `res_valid_o` rises at cycle 11.
- Column 2 = 200, others 0 -> gx=800, gy=0, res_data_o=255 (saturated).
- Only tap (0,0) = 10 -> gx=-10, gy=10, res_data_o=20.
- Column 0 = 255, others 0 -> gx=-1020, gy=0, res_data_o=255. Checks the negative bound and sign extension of 3'b110.
- Ack every third cycle; `res_ready_i` low for 5 cycles in OUT; `start_i` pulsed while busy:
  - exactly 9 acks consumed;
  - outputs stable until the handshake;
  - the extra start is ignored.
- Reset asserted during tap (1,1):
  - all outputs 0 and state IDLE asynchronously;
  - no `res_valid_o`;
  - the next window with pattern "tap (0,0)=10" yields 20.

Source files
------------

// File: rtl/edge_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector_pkg
// Description : Shared types and constants for the Sobel window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_detector_pkg;

  localparam int DEF_PIXEL_W = 8;
  localparam int DEF_ACC_W   = 12;
  localparam int TAP_COUNT   = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_MAG  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Row-major linear tap number (row*3 + col) of a 3x3 kernel index.
  function automatic logic [3:0] tap_linear(input logic [2:0] row, input logic [2:0] col);
    return ({1'b0, row} << 1) + {1'b0, row} + {1'b0, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detector_mag.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector_mag
// Description : Combinational |gx|+|gy| with saturation to PIXEL_W all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector_mag #(
  parameter int PIXEL_W = 8,
  parameter int ACC_W   = 12
) (
  input  logic signed [ACC_W-1:0]   gx_i,
  input  logic signed [ACC_W-1:0]   gy_i,
  output logic        [PIXEL_W-1:0] mag_o
);

  localparam logic [ACC_W-1:0] C_ONE = ACC_W'(1);

  logic [ACC_W-1:0] abs_gx;
  logic [ACC_W-1:0] abs_gy;
  logic [ACC_W:0]   sum;

  // Absolute values, one extra bit for the sum, then clamp anything above PIXEL_W.
  always_comb begin
    abs_gx = gx_i[ACC_W-1] ? (~gx_i + C_ONE) : gx_i;
    abs_gy = gy_i[ACC_W-1] ? (~gy_i + C_ONE) : gy_i;
    sum    = {1'b0, abs_gx} + {1'b0, abs_gy};
    if (|sum[ACC_W:PIXEL_W]) begin
      mag_o = '1;
    end else begin
      mag_o = sum[PIXEL_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_detector_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector_conv_ctrl
// Description : Steps a 3x3 Sobel window tap by tap over a req/ack pixel port,
//               accumulates signed Gx/Gy and presents the saturated magnitude
//               on a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector_conv_ctrl
  import edge_detector_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic [2:0]                Xindex_o,
  output logic [2:0]                Yindex_o,
  input  logic [2:0]                Kx_i,
  input  logic [2:0]                Ky_i,
  output logic                      pix_req_o,
  input  logic                      pix_ack_i,
  input  logic [PIXEL_W-1:0]        pix_data_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [PIXEL_W-1:0]        res_data_o,
  output logic signed [ACC_W-1:0]   gx_o,
  output logic signed [ACC_W-1:0]   gy_o
);

  state_e state_q, state_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic signed [ACC_W-1:0] gx_acc_q, gx_acc_d;
  logic signed [ACC_W-1:0] gy_acc_q, gy_acc_d;
  logic signed [ACC_W-1:0] gx_out_q, gx_out_d;
  logic signed [ACC_W-1:0] gy_out_q, gy_out_d;
  logic [PIXEL_W-1:0]      res_q, res_d;

  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] kx_ext;
  logic signed [ACC_W-1:0] ky_ext;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] prod_y;
  logic [PIXEL_W-1:0]      mag_w;
  logic                    last_tap;

  edge_detector_mag #(
    .PIXEL_W (PIXEL_W),
    .ACC_W   (ACC_W)
  ) u_mag (
    .gx_i  (gx_acc_q),
    .gy_i  (gy_acc_q),
    .mag_o (mag_w)
  );

  // Pixel is unsigned (zero-extend); 3-bit coefficients are two's complement.
  always_comb begin
    pix_ext  = $signed({{(ACC_W-PIXEL_W){1'b0}}, pix_data_i});
    kx_ext   = $signed({{(ACC_W-3){Kx_i[2]}}, Kx_i});
    ky_ext   = $signed({{(ACC_W-3){Ky_i[2]}}, Ky_i});
    prod_x   = pix_ext * kx_ext;
    prod_y   = pix_ext * ky_ext;
    last_tap = (tap_linear(x_q, y_q) == 4'(TAP_COUNT - 1));
  end

  // Next-state, tap stepping and accumulation.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    gx_acc_d = gx_acc_q;
    gy_acc_d = gy_acc_q;
    gx_out_d = gx_out_q;
    gy_out_d = gy_out_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_REQ;
          gx_acc_d = '0;
          gy_acc_d = '0;
          x_d      = 3'd0;
          y_d      = 3'd0;
        end
      end
      ST_REQ: begin
        if (pix_ack_i) begin
          gx_acc_d = gx_acc_q + prod_x;
          gy_acc_d = gy_acc_q + prod_y;
          if (last_tap) begin
            state_d = ST_MAG;
            x_d     = 3'd0;
            y_d     = 3'd0;
          end else if (y_q == 3'd2) begin
            x_d = x_q + 3'd1;
            y_d = 3'd0;
          end else begin
            y_d = y_q + 3'd1;
          end
        end
      end
      ST_MAG: begin
        gx_out_d = gx_acc_q;
        gy_out_d = gy_acc_q;
        res_d    = mag_w;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, index, accumulator and result registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      x_q      <= 3'd0;
      y_q      <= 3'd0;
      gx_acc_q <= '0;
      gy_acc_q <= '0;
      gx_out_q <= '0;
      gy_out_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gx_acc_q <= gx_acc_d;
      gy_acc_q <= gy_acc_d;
      gx_out_q <= gx_out_d;
      gy_out_q <= gy_out_d;
      res_q    <= res_d;
    end
  end

  // Status and handshake outputs decode straight from the state register.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    pix_req_o   = (state_q == ST_REQ);
    res_valid_o = (state_q == ST_OUT);
    Xindex_o    = x_q;
    Yindex_o    = y_q;
    res_data_o  = res_q;
    gx_o        = gx_out_q;
    gy_o        = gy_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detector_conv_ctrl
// Description : Self-checking bench for the Sobel window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detector_conv_ctrl;

  localparam int PW = 8;
  localparam int AW = 12;

  logic                 clk_i = 1'b0;
  logic                 rstn_i = 1'b0;
  logic                 start_i = 1'b0;
  logic                 busy_o;
  logic [2:0]           Xindex_o;
  logic [2:0]           Yindex_o;
  logic [2:0]           Kx_i;
  logic [2:0]           Ky_i;
  logic                 pix_req_o;
  logic                 pix_ack_i = 1'b0;
  logic [PW-1:0]        pix_data_i;
  logic                 res_valid_o;
  logic                 res_ready_i = 1'b0;
  logic [PW-1:0]        res_data_o;
  logic signed [AW-1:0] gx_o;
  logic signed [AW-1:0] gy_o;

  typedef struct {
    int gx;
    int gy;
    int mag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int        kx_tab [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int        ky_tab [3][3] = '{'{ 1, 2, 1}, '{ 0, 0, 0}, '{-1,-2,-1}};
  logic [7:0] win   [3][3];

  edge_detector_conv_ctrl #(.PIXEL_W(PW), .ACC_W(AW)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .Xindex_o    (Xindex_o),
    .Yindex_o    (Yindex_o),
    .Kx_i        (Kx_i),
    .Ky_i        (Ky_i),
    .pix_req_o   (pix_req_o),
    .pix_ack_i   (pix_ack_i),
    .pix_data_i  (pix_data_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .gx_o        (gx_o),
    .gy_o        (gy_o)
  );

  always #5 clk_i = ~clk_i;

  // External coefficient lookup and window pixel source, both combinational.
  always_comb begin
    Kx_i       = 3'b000;
    Ky_i       = 3'b000;
    pix_data_i = '0;
    if (Xindex_o < 3'd3 && Yindex_o < 3'd3) begin
      Kx_i       = 3'(kx_tab[Xindex_o[1:0]][Yindex_o[1:0]]);
      Ky_i       = 3'(ky_tab[Xindex_o[1:0]][Yindex_o[1:0]]);
      pix_data_i = win[Xindex_o[1:0]][Yindex_o[1:0]];
    end
  end

  task automatic load_pattern(input int kind);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        case (kind)
          0: win[r][c] = 8'd100;
          1: win[r][c] = (c == 2) ? 8'd200 : 8'd0;
          2: win[r][c] = (r == 0 && c == 0) ? 8'd10 : 8'd0;
          3: win[r][c] = (c == 0) ? 8'd255 : 8'd0;
          default: win[r][c] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int s;
    e.gx = 0;
    e.gy = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        e.gx += int'(win[r][c]) * kx_tab[r][c];
        e.gy += int'(win[r][c]) * ky_tab[r][c];
      end
    end
    s = (e.gx < 0 ? -e.gx : e.gx) + (e.gy < 0 ? -e.gy : e.gy);
    e.mag = (s > 255) ? 255 : s;
    sb.push_back(e);
  endtask

  // One complete window: start, feed taps, optional stall in OUT, handshake.
  task automatic run_window(input string name, input int ack_period, input int stall,
                            input bit extra_start, input bit check_rise);
    int   cyc;
    int   acks;
    int   phase;
    bit   ack_now;
    exp_t e;
    push_expected();
    @(negedge clk_i);
    start_i     = 1'b1;
    res_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cyc   = 1;
    acks  = 0;
    phase = 0;
    while (!res_valid_o && cyc < 300) begin
      @(negedge clk_i);
      ack_now   = ((phase % ack_period) == ack_period - 1);
      phase++;
      pix_ack_i = ack_now;
      start_i   = extra_start && (cyc == 4);
      if (pix_req_o && ack_now) acks++;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    @(negedge clk_i);
    pix_ack_i = 1'b0;
    start_i   = 1'b0;
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_timeout: valid=%b after %0d cycles, required 1", name, res_valid_o, cyc);
      return;
    end
    checks++;
    if (acks !== 9) begin
      errors++;
      $display("FAIL %s ack_count: consumed %0d, required 9", name, acks);
    end
    if (check_rise) begin
      checks++;
      if (cyc !== 11) begin
        errors++;
        $display("FAIL %s valid_rise: cycle %0d, required 11", name, cyc);
      end
    end
    e = sb[0];
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (res_valid_o !== 1'b1 || res_data_o !== 8'(e.mag) || gx_o !== 12'(e.gx) || gy_o !== 12'(e.gy)) begin
        errors++;
        $display("FAIL %s hold[%0d]: valid=%b res=%0d gx=%0d gy=%0d, required valid=1 res=%0d gx=%0d gy=%0d",
                 name, i, res_valid_o, res_data_o, gx_o, gy_o, e.mag, e.gx, e.gy);
      end
      @(negedge clk_i);
    end
    res_ready_i = 1'b1;
    e = sb.pop_front();
    checks++;
    if (res_data_o !== 8'(e.mag) || gx_o !== 12'(e.gx) || gy_o !== 12'(e.gy)) begin
      errors++;
      $display("FAIL %s result: res=%0d gx=%0d gy=%0d, required res=%0d gx=%0d gy=%0d",
               name, res_data_o, gx_o, gy_o, e.mag, e.gx, e.gy);
    end
    @(negedge clk_i);
    res_ready_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_drop: valid=%b after handshake, required 0", name, res_valid_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b, required 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy_o !== 1'b0 || pix_req_o !== 1'b0 || res_valid_o !== 1'b0 || Xindex_o !== 3'd0 ||
        Yindex_o !== 3'd0 || res_data_o !== 8'd0 || gx_o !== 12'd0 || gy_o !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b req=%b valid=%b x=%0d y=%0d res=%0d gx=%0d gy=%0d, required all 0",
               busy_o, pix_req_o, res_valid_o, Xindex_o, Yindex_o, res_data_o, gx_o, gy_o);
    end
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_patterns();
    load_pattern(0); run_window("uniform", 1, 0, 1'b0, 1'b1);
    load_pattern(1); run_window("col2_200", 1, 0, 1'b0, 1'b1);
    load_pattern(2); run_window("tap00_10", 1, 0, 1'b0, 1'b1);
    load_pattern(3); run_window("col0_255", 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_slow_ack_stall();
    load_pattern(4);
    run_window("slow_ack", 3, 5, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   rise [2];
    int   nres;
    exp_t e;
    load_pattern(4);
    push_expected();
    push_expected();
    nres = 0;
    @(negedge clk_i);
    start_i     = 1'b1;
    res_ready_i = 1'b1;
    pix_ack_i   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_i);
      #1;
      if (n == 13) start_i = 1'b0;
      if (res_valid_o && nres < 2) begin
        rise[nres] = n;
        e = sb.pop_front();
        checks++;
        if (res_data_o !== 8'(e.mag) || gx_o !== 12'(e.gx) || gy_o !== 12'(e.gy)) begin
          errors++;
          $display("FAIL b2b_result[%0d]: res=%0d gx=%0d gy=%0d, required res=%0d gx=%0d gy=%0d",
                   nres, res_data_o, gx_o, gy_o, e.mag, e.gx, e.gy);
        end
        nres++;
      end
    end
    start_i     = 1'b0;
    res_ready_i = 1'b0;
    pix_ack_i   = 1'b0;
    checks++;
    if (nres !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 2", nres);
      while (sb.size() > 0) void'(sb.pop_front());
    end else begin
      checks++;
      if (rise[0] !== 11 || rise[1] - rise[0] !== 12) begin
        errors++;
        $display("FAIL b2b_period: rises at %0d and %0d, required 11 and 23", rise[0], rise[1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit found;
    int vseen;
    load_pattern(4);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      pix_ack_i = 1'b1;
      if (pix_req_o && Xindex_o == 3'd1 && Yindex_o == 3'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach_tap11: tap (1,1) not seen, required within 20 cycles");
    end
    #1;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || pix_req_o !== 1'b0 || res_valid_o !== 1'b0 || Xindex_o !== 3'd0 ||
        Yindex_o !== 3'd0 || res_data_o !== 8'd0 || gx_o !== 12'd0 || gy_o !== 12'd0) begin
      errors++;
      $display("FAIL abort_async: busy=%b req=%b valid=%b x=%0d y=%0d res=%0d gx=%0d gy=%0d, required all 0",
               busy_o, pix_req_o, res_valid_o, Xindex_o, Yindex_o, res_data_o, gx_o, gy_o);
    end
    pix_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    vseen  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (res_valid_o || busy_o) vseen++;
    end
    checks++;
    if (vseen !== 0) begin
      errors++;
      $display("FAIL abort_no_result: %0d busy/valid cycles after abort, required 0", vseen);
    end
    load_pattern(2);
    run_window("after_abort", 1, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_slow_ack_stall();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
